// File: rtl/dbf_ch_interp.sv
// Per-channel beamforming datapath: coarse delay buffer, fine-delay interpolation, apodisation.
// Define DBF_FINE_DELAY_EN for two-tap linear interpolation; otherwise tap a passes straight through.
module dbf_ch_interp #(
    parameter int unsigned INPUT_WD = 14,
    parameter int unsigned APO_WD   = 16,
    parameter int unsigned FRAC_WD  = 4,
    parameter int unsigned BUF_AW   = 7,
    parameter int unsigned LUT_AW   = 10,
    parameter int unsigned OUT_WD   = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      tx_en,
    input  logic                      start,
    input  logic [INPUT_WD-1:0]       ch_in,
    input  logic [APO_WD-1:0]         apo_din,
    input  logic                      lut_wr_en,
    input  logic [LUT_AW-1:0]         lut_addr,
    input  logic [BUF_AW+FRAC_WD-1:0] lut_wdata,
    output logic [OUT_WD-1:0]         dout,
    output logic                      dout_valid,
    output logic [INPUT_WD-1:0]       cd_dout
);
    localparam int unsigned LUT_DW = BUF_AW + FRAC_WD;
    localparam int unsigned I_WD   = INPUT_WD + 1;
    localparam int unsigned P_WD   = I_WD + APO_WD;
    localparam logic [BUF_AW:0]   FILL_MAX = {1'b1, {BUF_AW{1'b0}}};
    localparam logic [BUF_AW-1:0] C_MAX    = {{(BUF_AW-1){1'b1}}, 1'b0};

    typedef enum logic {StIdle, StRun} state_e;

    state_e                     state_q, state_d;
    logic                       accept;
    logic [LUT_AW-1:0]          k_q, k_d;
    logic [BUF_AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [BUF_AW:0]            fill_q, fill_d;

    logic                       in_vld_q, in_vld_d;
    logic signed [INPUT_WD-1:0] in_x_q, in_x_d;
    logic signed [APO_WD-1:0]   in_apo_q, in_apo_d;
    logic [BUF_AW-1:0]          in_addr_q, in_addr_d;
    logic [BUF_AW:0]            in_fill_q, in_fill_d;
    logic [LUT_AW-1:0]          in_k_q, in_k_d;

    logic                       s1_vld_q, s1_vld_d;
    logic [BUF_AW-1:0]          s1_addr_q, s1_addr_d;
    logic [BUF_AW:0]            s1_fill_q, s1_fill_d;
    logic signed [APO_WD-1:0]   s1_apo_q, s1_apo_d;
    logic [LUT_DW-1:0]          lut_rd_q;

    logic                       s2_vld_q, s2_vld_d;
    logic signed [INPUT_WD-1:0] a_q, a_d;
    logic signed [APO_WD-1:0]   s2_apo_q, s2_apo_d;

    logic                       s3_vld_q, s3_vld_d;
    logic signed [I_WD-1:0]     i_q, i_d;
    logic signed [APO_WD-1:0]   s3_apo_q, s3_apo_d;

    logic                       dout_valid_q, dout_valid_d;
    logic [OUT_WD-1:0]          dout_q, dout_d;

    logic [INPUT_WD-1:0]        buf_mem [2**BUF_AW];
    logic [LUT_DW-1:0]          lut_mem [2**LUT_AW];

    logic [BUF_AW-1:0]          coarse, c_clamp, a_addr;
    logic signed [INPUT_WD-1:0] tap_a;
    logic signed [I_WD-1:0]     interp;
    logic signed [P_WD-1:0]     prod;
    logic                       s2_load;

`ifdef DBF_FINE_DELAY_EN
    localparam int unsigned ACC_WD = INPUT_WD + FRAC_WD + 3;
    localparam logic signed [FRAC_WD+1:0] W_ONE = (FRAC_WD+2)'(2**FRAC_WD);
    localparam logic signed [ACC_WD-1:0]  RND   = ACC_WD'(2**(FRAC_WD-1));

    logic [BUF_AW-1:0]          b_addr;
    logic [BUF_AW:0]            c_b;
    logic signed [INPUT_WD-1:0] tap_b, b_q, b_d;
    logic [FRAC_WD-1:0]         f_q, f_d;
    logic signed [FRAC_WD+1:0]  w_a, w_b;
    logic signed [ACC_WD-1:0]   acc;
`else
    logic                       unused_frac;
    assign unused_frac = ^lut_rd_q[FRAC_WD-1:0];
`endif

    // Acquisition control; dropping start returns everything to the empty state.
    always_comb begin
        accept   = start && !tx_en;
        state_d  = state_q;
        k_d      = k_q;
        wr_ptr_d = wr_ptr_q;
        fill_d   = fill_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StRun;
            StRun:   if (!start) state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (!start) begin
            k_d      = '0;
            wr_ptr_d = '0;
            fill_d   = '0;
        end else if (accept) begin
            if (k_q != '1) k_d = k_q + LUT_AW'(1);
            wr_ptr_d = wr_ptr_q + BUF_AW'(1);
            if (fill_q != FILL_MAX) fill_d = fill_q + (BUF_AW+1)'(1);
        end
        in_vld_d  = accept;
        in_x_d    = accept ? $signed(ch_in) : in_x_q;
        in_apo_d  = accept ? $signed(apo_din) : in_apo_q;
        in_addr_d = accept ? wr_ptr_q : in_addr_q;
        in_fill_d = accept ? fill_d : in_fill_q;
        in_k_d    = accept ? k_q : in_k_q;
        s1_vld_d  = in_vld_q && start;
        s1_addr_d = in_vld_q ? in_addr_q : s1_addr_q;
        s1_fill_d = in_vld_q ? in_fill_q : s1_fill_q;
        s1_apo_d  = in_vld_q ? in_apo_q : s1_apo_q;
    end

    // Tap reads, interpolation and apodisation.
    always_comb begin
        coarse   = lut_rd_q[LUT_DW-1:FRAC_WD];
        c_clamp  = (coarse > C_MAX) ? C_MAX : coarse;
        a_addr   = s1_addr_q - c_clamp;
        // A tap older than sample 0 of this run has not been written yet.
        tap_a    = ({1'b0, c_clamp} < s1_fill_q) ? $signed(buf_mem[a_addr]) : '0;
        s2_load  = s1_vld_q && start;
        s2_vld_d = s2_load;
        a_d      = s2_load ? tap_a : a_q;
        s2_apo_d = s2_load ? s1_apo_q : s2_apo_q;
`ifdef DBF_FINE_DELAY_EN
        c_b    = {1'b0, c_clamp} + (BUF_AW+1)'(1);
        b_addr = a_addr - BUF_AW'(1);
        tap_b  = (c_b < s1_fill_q) ? $signed(buf_mem[b_addr]) : '0;
        b_d    = s2_load ? tap_b : b_q;
        f_d    = s2_load ? lut_rd_q[FRAC_WD-1:0] : f_q;
        w_b    = $signed({2'b00, f_q});
        w_a    = W_ONE - w_b;
        acc    = ACC_WD'(a_q) * ACC_WD'(w_a) + ACC_WD'(b_q) * ACC_WD'(w_b) + RND;
        interp = I_WD'(acc >>> FRAC_WD);
`else
        interp = I_WD'(a_q);
`endif
        s3_vld_d     = s2_vld_q && start;
        i_d          = s2_vld_q ? interp : i_q;
        s3_apo_d     = s2_vld_q ? s2_apo_q : s3_apo_q;
        prod         = P_WD'(i_q) * P_WD'(s3_apo_q);
        dout_valid_d = s3_vld_q && start;
        dout_d       = dout_valid_d ? OUT_WD'(prod) : '0;
    end

    // Storage arrays are not reset; fill count masks stale buffer entries.
    always_ff @(posedge clk) begin
        if (in_vld_q) buf_mem[in_addr_q] <= in_x_q;
    end

    always_ff @(posedge clk) begin
        if (lut_wr_en) lut_mem[lut_addr] <= lut_wdata;
        lut_rd_q <= lut_mem[in_k_q];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            k_q          <= '0;
            wr_ptr_q     <= '0;
            fill_q       <= '0;
            in_vld_q     <= 1'b0;
            in_x_q       <= '0;
            in_apo_q     <= '0;
            in_addr_q    <= '0;
            in_fill_q    <= '0;
            in_k_q       <= '0;
            s1_vld_q     <= 1'b0;
            s1_addr_q    <= '0;
            s1_fill_q    <= '0;
            s1_apo_q     <= '0;
            s2_vld_q     <= 1'b0;
            a_q          <= '0;
            s2_apo_q     <= '0;
            s3_vld_q     <= 1'b0;
            i_q          <= '0;
            s3_apo_q     <= '0;
            dout_valid_q <= 1'b0;
            dout_q       <= '0;
`ifdef DBF_FINE_DELAY_EN
            b_q          <= '0;
            f_q          <= '0;
`endif
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            wr_ptr_q     <= wr_ptr_d;
            fill_q       <= fill_d;
            in_vld_q     <= in_vld_d;
            in_x_q       <= in_x_d;
            in_apo_q     <= in_apo_d;
            in_addr_q    <= in_addr_d;
            in_fill_q    <= in_fill_d;
            in_k_q       <= in_k_d;
            s1_vld_q     <= s1_vld_d;
            s1_addr_q    <= s1_addr_d;
            s1_fill_q    <= s1_fill_d;
            s1_apo_q     <= s1_apo_d;
            s2_vld_q     <= s2_vld_d;
            a_q          <= a_d;
            s2_apo_q     <= s2_apo_d;
            s3_vld_q     <= s3_vld_d;
            i_q          <= i_d;
            s3_apo_q     <= s3_apo_d;
            dout_valid_q <= dout_valid_d;
            dout_q       <= dout_d;
`ifdef DBF_FINE_DELAY_EN
            b_q          <= b_d;
            f_q          <= f_d;
`endif
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign cd_dout    = a_q;

endmodule

// File: tb/tb_dbf_ch_interp.sv
// Self-checking bench for dbf_ch_interp: randomized stimulus against a sample-history reference model.
module tb_dbf_ch_interp;
    logic        clk, rst_n, tx_en, start, lut_wr_en, dout_valid;
    logic [13:0] ch_in, cd_dout;
    logic [15:0] apo_din;
    logic [9:0]  lut_addr;
    logic [10:0] lut_wdata;
    logic [31:0] dout;

    int   checks = 0;
    int   errors = 0;
    int   m_lut [1024];
    int   hist [$];
    logic rv [8];
    int   rd [8];
    logic cv [8];
    int   cr [8];
    int   cyc = 0;
    int   cd_hold = 0;

    dbf_ch_interp dut (
        .clk(clk), .rst_n(rst_n), .tx_en(tx_en), .start(start), .ch_in(ch_in),
        .apo_din(apo_din), .lut_wr_en(lut_wr_en), .lut_addr(lut_addr), .lut_wdata(lut_wdata),
        .dout(dout), .dout_valid(dout_valid), .cd_dout(cd_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_flush();
        for (int j = 0; j < 8; j++) begin
            rv[j] = 1'b0;
            cv[j] = 1'b0;
        end
        hist.delete();
    endfunction

    // One clock: drive inputs, advance the model by one edge, return what the outputs should be.
    task automatic run_cycle(input logic st, input logic tx, input int x, input int ap,
                             output logic ev, output int ed, output int ec);
        int k, e, c, f, a, b, i;
        start = st; tx_en = tx; ch_in = x[13:0]; apo_din = ap[15:0];
        @(posedge clk);
        cyc++;
        if (!st) begin
            for (int j = 0; j < 4; j++) begin
                rv[(cyc + j) % 8] = 1'b0;
                cv[(cyc + j) % 8] = 1'b0;
            end
            hist.delete();
        end else if (!tx) begin
            k = hist.size();
            hist.push_back(x);
            e = m_lut[(k > 1023) ? 1023 : k];
            c = e >> 4;
            if (c > 126) c = 126;
            f = e & 15;
            a = (k - c >= 0) ? hist[k - c] : 0;
            b = (k - c - 1 >= 0) ? hist[k - c - 1] : 0;
`ifdef DBF_FINE_DELAY_EN
            i = (a * (16 - f) + b * f + 8) >>> 4;
`else
            i = a;
`endif
            rv[(cyc + 4) % 8] = 1'b1;
            rd[(cyc + 4) % 8] = i * ap;
            cv[(cyc + 2) % 8] = 1'b1;
            cr[(cyc + 2) % 8] = a;
        end
        if (cv[cyc % 8]) cd_hold = cr[cyc % 8];
        ev = rv[cyc % 8];
        ed = ev ? rd[cyc % 8] : 0;
        ec = cd_hold;
        rv[cyc % 8] = 1'b0;
        cv[cyc % 8] = 1'b0;
        #1;
    endtask

    task automatic lut_write(input int addr, input int data);
        start = 1'b0; lut_wr_en = 1'b1; lut_addr = addr[9:0]; lut_wdata = data[10:0];
        @(posedge clk);
        #1;
        lut_wr_en = 1'b0;
        m_lut[addr] = data;
        model_flush();
    endtask

    task automatic lut_fill(input int data);
        for (int n = 0; n < 1024; n++) lut_write(n, data);
    endtask

    function automatic int rnd_x();
        return int'($urandom_range(0, 16383)) - 8192;
    endfunction

    function automatic int rnd_apo();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    task automatic test_reset();
        logic ev; int ed, ec;
        rst_n = 1'b0;
        for (int n = 0; n < 6; n++) begin
            start = 1'($urandom); tx_en = 1'($urandom);
            ch_in = 14'($urandom); apo_din = 16'($urandom);
            @(posedge clk);
            #1;
            checks++;
            if ({dout_valid, dout, cd_dout} !== '0) begin
                errors++;
                $display("FAIL reset_hold n=%0d got v=%b d=%0h cd=%0h, want all 0",
                         n, dout_valid, dout, cd_dout);
            end
        end
        rst_n = 1'b1;
        model_flush();
        cd_hold = 0;
        for (int n = 0; n < 4; n++) begin
            run_cycle(1'b0, 1'($urandom), rnd_x(), rnd_apo(), ev, ed, ec);
            checks++;
            if ({dout_valid, dout, cd_dout} !== '0) begin
                errors++;
                $display("FAIL reset_idle n=%0d got v=%b d=%0h cd=%0h, want all 0",
                         n, dout_valid, dout, cd_dout);
            end
        end
    endtask

    task automatic test_coarse();
        logic ev; int ed, ec;
        lut_fill(3 << 4);
        for (int n = 0; n < 25; n++) begin
            run_cycle(1'b1, n >= 20, n, 1, ev, ed, ec);
            checks++;
            if ({dout_valid, dout} !== {ev, ed}) begin
                errors++;
                $display("FAIL coarse n=%0d got v=%b d=%0d want v=%b d=%0d",
                         n, dout_valid, $signed(dout), ev, ed);
            end
            checks++;
            if (cd_dout !== 14'(ec)) begin
                errors++;
                $display("FAIL coarse_cd n=%0d got %0d want %0d", n, $signed(cd_dout), ec);
            end
        end
    endtask

    task automatic test_stall();
        logic ev; int ed, ec;
        int nv = 0, nacc = 0;
        logic tx;
        for (int n = 0; n < 31; n++) begin
            tx = (n >= 10 && n < 13) || n >= 26;
            if (!tx) nacc++;
            run_cycle(1'b1, tx, rnd_x(), rnd_apo(), ev, ed, ec);
            if (dout_valid) nv++;
            checks++;
            if ({dout_valid, dout} !== {ev, ed}) begin
                errors++;
                $display("FAIL stall n=%0d got v=%b d=%0d want v=%b d=%0d",
                         n, dout_valid, $signed(dout), ev, ed);
            end
            checks++;
            if (cd_dout !== 14'(ec)) begin
                errors++;
                $display("FAIL stall_cd n=%0d got %0d want %0d", n, $signed(cd_dout), ec);
            end
        end
        checks++;
        if (nv !== nacc) begin
            errors++;
            $display("FAIL stall_count got %0d valids want %0d", nv, nacc);
        end
    endtask

    task automatic test_abort();
        logic ev; int ed, ec;
        for (int n = 0; n < 26; n++) begin
            run_cycle(n != 8, n >= 21, rnd_x(), rnd_apo(), ev, ed, ec);
            checks++;
            if ({dout_valid, dout} !== {ev, ed}) begin
                errors++;
                $display("FAIL abort n=%0d got v=%b d=%0d want v=%b d=%0d",
                         n, dout_valid, $signed(dout), ev, ed);
            end
            checks++;
            if (cd_dout !== 14'(ec)) begin
                errors++;
                $display("FAIL abort_cd n=%0d got %0d want %0d", n, $signed(cd_dout), ec);
            end
            if (n == 8) begin
                checks++;
                if (dout_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL abort_drop got v=%b want 0", dout_valid);
                end
            end
        end
    endtask

    task automatic test_fine();
        logic ev; int ed, ec;
        lut_fill((2 << 4) | 8);
        for (int n = 0; n < 25; n++) begin
            run_cycle(1'b1, n >= 20, n, 1, ev, ed, ec);
            checks++;
            if ({dout_valid, dout} !== {ev, ed}) begin
                errors++;
                $display("FAIL fine n=%0d got v=%b d=%0d want v=%b d=%0d",
                         n, dout_valid, $signed(dout), ev, ed);
            end
        end
    endtask

    task automatic test_apo();
        logic ev; int ed, ec;
        lut_fill(0);
        for (int n = 0; n < 19; n++) begin
            if (n < 8) run_cycle(1'b1, 1'b0, 100, -3, ev, ed, ec);
            else       run_cycle(1'b1, n >= 14, -8192, -32768, ev, ed, ec);
            checks++;
            if ({dout_valid, dout} !== {ev, ed}) begin
                errors++;
                $display("FAIL apo n=%0d got v=%b d=%0d want v=%b d=%0d",
                         n, dout_valid, $signed(dout), ev, ed);
            end
            if (n == 4 || n == 12) begin
                checks++;
                if (dout !== ((n == 4) ? -32'sd300 : 32'sd268435456)) begin
                    errors++;
                    $display("FAIL apo_const n=%0d got %0d", n, $signed(dout));
                end
            end
        end
    endtask

    task automatic test_focus();
        logic ev; int ed, ec;
        lut_write(10, 5 << 4);
        for (int n = 0; n < 25; n++) begin
            run_cycle(1'b1, n >= 20, n, 1, ev, ed, ec);
            checks++;
            if ({dout_valid, dout} !== {ev, ed}) begin
                errors++;
                $display("FAIL focus n=%0d got v=%b d=%0d want v=%b d=%0d",
                         n, dout_valid, $signed(dout), ev, ed);
            end
            if (n == 14) begin
                checks++;
                if (dout !== 32'd5) begin
                    errors++;
                    $display("FAIL focus_10 got %0d want 5", $signed(dout));
                end
            end
        end
    endtask

    task automatic test_wrap();
        logic ev; int ed, ec;
        lut_fill(126 << 4);
        for (int n = 0; n < 305; n++) begin
            run_cycle(1'b1, n >= 300, n, 1, ev, ed, ec);
            checks++;
            if ({dout_valid, dout} !== {ev, ed}) begin
                errors++;
                $display("FAIL wrap n=%0d got v=%b d=%0d want v=%b d=%0d",
                         n, dout_valid, $signed(dout), ev, ed);
            end
        end
    endtask

    task automatic test_random();
        logic ev; int ed, ec;
        for (int n = 0; n < 1024; n++) lut_write(n, int'($urandom_range(0, 2047)));
        for (int n = 0; n < 600; n++) begin
            run_cycle($urandom_range(0, 99) < 92, $urandom_range(0, 99) < 15,
                      rnd_x(), rnd_apo(), ev, ed, ec);
            checks++;
            if ({dout_valid, dout} !== {ev, ed}) begin
                errors++;
                $display("FAIL random n=%0d got v=%b d=%0d want v=%b d=%0d",
                         n, dout_valid, $signed(dout), ev, ed);
            end
            checks++;
            if (cd_dout !== 14'(ec)) begin
                errors++;
                $display("FAIL random_cd n=%0d got %0d want %0d", n, $signed(cd_dout), ec);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic ev; int ed, ec;
        for (int n = 0; n < 12; n++) run_cycle(1'b1, 1'b0, rnd_x(), rnd_apo(), ev, ed, ec);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({dout_valid, dout, cd_dout} !== '0) begin
            errors++;
            $display("FAIL reset_async got v=%b d=%0h cd=%0h, want all 0",
                     dout_valid, dout, cd_dout);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_flush();
        cd_hold = 0;
        for (int n = 0; n < 20; n++) begin
            run_cycle(1'b1, n >= 15, rnd_x(), rnd_apo(), ev, ed, ec);
            checks++;
            if ({dout_valid, dout} !== {ev, ed}) begin
                errors++;
                $display("FAIL reset_restart n=%0d got v=%b d=%0d want v=%b d=%0d",
                         n, dout_valid, $signed(dout), ev, ed);
            end
            checks++;
            if (cd_dout !== 14'(ec)) begin
                errors++;
                $display("FAIL reset_restart_cd n=%0d got %0d want %0d",
                         n, $signed(cd_dout), ec);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; tx_en = 1'b0; ch_in = '0; apo_din = '0;
        lut_wr_en = 1'b0; lut_addr = '0; lut_wdata = '0;
        model_flush();
        test_reset();
        test_coarse();
        test_stall();
        test_abort();
        test_fine();
        test_apo();
        test_focus();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
